// File: rtl/placement_cost_eval_if.sv
// placement_cost_eval_if
// ----------------------
// Bus bundle between the wirelength evaluator and its environment: the
// start/busy/done control handshake plus the read ports of the edge ROMs
// (EA/EB) and the final position RAMs (pos_X/pos_Y).
//
// Signals
//   start      : one-cycle request from the controller
//   busy       : evaluator is walking the edge list
//   done       : one-cycle pulse, result outputs valid from this cycle on
//   edge_rd    : read strobe to EA/EB, edge_addr = edge index
//   edge_a/b   : EA/EB read data (node IDs)
//   pos_rd     : read strobe to pos_X/pos_Y, pos_addr = node ID
//   pos_x/y    : position read data, -1 marks an unplaced node
//
// Handshake semantics: start is a request that is only taken while the
// evaluator is idle; any start seen while busy or in the done cycle is dropped.
// done is the completion pulse and busy is low during it. Memory reads are
// fixed-latency: a strobe is high for exactly one cycle with its address,
// the memory samples both at the closing edge of that cycle, and the read
// data must be stable during the whole following cycle, when it is captured.
//
// Modports
//   master : controller + memories side (drives start and read data)
//   slave  : evaluator side
interface placement_cost_eval_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              start;
    logic              busy;
    logic              done;
    logic              edge_rd;
    logic [ADDR_W-1:0] edge_addr;
    logic [DATA_W-1:0] edge_a;
    logic [DATA_W-1:0] edge_b;
    logic              pos_rd;
    logic [ADDR_W-1:0] pos_addr;
    logic [DATA_W-1:0] pos_x;
    logic [DATA_W-1:0] pos_y;

    modport master (
        output start, edge_a, edge_b, pos_x, pos_y,
        input  busy, done, edge_rd, edge_addr, pos_rd, pos_addr
    );

    modport slave (
        input  start, edge_a, edge_b, pos_x, pos_y,
        output busy, done, edge_rd, edge_addr, pos_rd, pos_addr
    );
endinterface

// File: rtl/placement_cost_eval.sv
// placement_cost_eval
// -------------------
// Post-placement wirelength evaluator. Walks the N_EDGE entries of the edge
// list, fetches both endpoint positions and accumulates Manhattan, Chebyshev
// and 1-hop (ceil-halved Manhattan) sums, the longest placed edge and the
// number of edges with an unplaced endpoint. Each edge takes 8 cycles.
//
// Ports
//   clk          : rising-edge clock
//   reset        : asynchronous, active-high; clears all state and outputs
//   bus          : placement_cost_eval_if.slave (start/busy/done + memory reads)
//   sum_manh     : sum of |dx|+|dy| over placed edges (wraps)
//   sum_cheb     : sum of max(|dx|,|dy|) over placed edges (wraps)
//   sum_1hop     : sum of ceil(|dx|/2)+ceil(|dy|/2) over placed edges (wraps)
//   max_len      : largest |dx|+|dy| over placed edges
//   unplaced_cnt : edges skipped because an endpoint coordinate is -1 (saturates)
//   state_dbg    : current FSM state, for observation only
//   cycles       : only with PLACE_EVAL_CYCLES_EN; cycles from accepted start
//                  through the done cycle inclusive
//
// Optional feature macro: PLACE_EVAL_CYCLES_EN (adds cycles port, the cycle
// counter and a result printout in the done cycle).
module placement_cost_eval #(
    parameter int N_EDGE = 22,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ACC_W  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    placement_cost_eval_if.slave bus,
    output logic [ACC_W-1:0]     sum_manh,
    output logic [ACC_W-1:0]     sum_cheb,
    output logic [ACC_W-1:0]     sum_1hop,
    output logic [DATA_W-1:0]    max_len,
    output logic [15:0]          unplaced_cnt,
    output logic [3:0]           state_dbg
`ifdef PLACE_EVAL_CYCLES_EN
    ,
    output logic [31:0]          cycles
`endif
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        E_REQ  = 4'd1,
        E_WAIT = 4'd2,
        A_REQ  = 4'd3,
        A_WAIT = 4'd4,
        B_REQ  = 4'd5,
        B_WAIT = 4'd6,
        CALC   = 4'd7,
        ACC    = 4'd8,
        DONE   = 4'd9
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'((N_EDGE > 0) ? N_EDGE - 1 : 0);
    localparam logic [DATA_W-1:0] UNPLACED = '1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0]   ax_q, ax_d, ay_q, ay_d, bx_q, bx_d, by_q, by_d;
    logic [DATA_W-1:0]   dx_q, dx_d, dy_q, dy_d;
    logic                skip_q, skip_d;
    logic [ACC_W-1:0]    sum_manh_q, sum_manh_d;
    logic [ACC_W-1:0]    sum_cheb_q, sum_cheb_d;
    logic [ACC_W-1:0]    sum_1hop_q, sum_1hop_d;
    logic [DATA_W-1:0]   max_len_q, max_len_d;
    logic [15:0]         unplaced_cnt_q, unplaced_cnt_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                edge_rd_q, edge_rd_d, pos_rd_q, pos_rd_d;
    logic [ADDR_W-1:0]   edge_addr_q, edge_addr_d, pos_addr_q, pos_addr_d;
`ifdef PLACE_EVAL_CYCLES_EN
    logic [31:0]         cycles_q, cycles_d;
`endif

    // Per-edge terms. The subtraction is two's complement at DATA_W, so the
    // sign bit of the difference decides the absolute value.
    logic [DATA_W-1:0]   diff_x, diff_y;
    logic [DATA_W-1:0]   len_term, cheb_term, hop_term;

    assign diff_x    = ax_q - bx_q;
    assign diff_y    = ay_q - by_q;
    assign len_term  = dx_q + dy_q;
    assign cheb_term = (dx_q > dy_q) ? dx_q : dy_q;
    // ceil(v/2) = (v >> 1) + v[0]
    assign hop_term  = (dx_q >> 1) + {{(DATA_W-1){1'b0}}, dx_q[0]}
                     + (dy_q >> 1) + {{(DATA_W-1){1'b0}}, dy_q[0]};

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        a_d            = a_q;
        b_d            = b_q;
        ax_d           = ax_q;
        ay_d           = ay_q;
        bx_d           = bx_q;
        by_d           = by_q;
        dx_d           = dx_q;
        dy_d           = dy_q;
        skip_d         = skip_q;
        sum_manh_d     = sum_manh_q;
        sum_cheb_d     = sum_cheb_q;
        sum_1hop_d     = sum_1hop_q;
        max_len_d      = max_len_q;
        unplaced_cnt_d = unplaced_cnt_q;
`ifdef PLACE_EVAL_CYCLES_EN
        cycles_d       = cycles_q;
        if (state_q != IDLE && state_q != DONE) begin
            cycles_d = cycles_q + 32'd1;
        end
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    idx_d          = '0;
                    sum_manh_d     = '0;
                    sum_cheb_d     = '0;
                    sum_1hop_d     = '0;
                    max_len_d      = '0;
                    unplaced_cnt_d = '0;
`ifdef PLACE_EVAL_CYCLES_EN
                    // The first counted cycle is the one right after acceptance.
                    cycles_d       = 32'd1;
`endif
                    state_d = (N_EDGE == 0) ? DONE : E_REQ;
                end
            end
            E_REQ:  state_d = E_WAIT;
            E_WAIT: begin
                a_d     = bus.edge_a;
                b_d     = bus.edge_b;
                state_d = A_REQ;
            end
            A_REQ:  state_d = A_WAIT;
            A_WAIT: begin
                ax_d    = bus.pos_x;
                ay_d    = bus.pos_y;
                state_d = B_REQ;
            end
            B_REQ:  state_d = B_WAIT;
            B_WAIT: begin
                bx_d    = bus.pos_x;
                by_d    = bus.pos_y;
                state_d = CALC;
            end
            CALC: begin
                dx_d    = diff_x[DATA_W-1] ? ('0 - diff_x) : diff_x;
                dy_d    = diff_y[DATA_W-1] ? ('0 - diff_y) : diff_y;
                skip_d  = (ax_q == UNPLACED) || (ay_q == UNPLACED)
                       || (bx_q == UNPLACED) || (by_q == UNPLACED);
                state_d = ACC;
            end
            ACC: begin
                if (skip_q) begin
                    if (unplaced_cnt_q != 16'hFFFF) begin
                        unplaced_cnt_d = unplaced_cnt_q + 16'd1;
                    end
                end else begin
                    sum_manh_d = sum_manh_q + ACC_W'(dx_q) + ACC_W'(dy_q);
                    sum_cheb_d = sum_cheb_q + ACC_W'(cheb_term);
                    sum_1hop_d = sum_1hop_q + ACC_W'(hop_term);
                    if (len_term > max_len_q) begin
                        max_len_d = len_term;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = E_REQ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Registered outputs are derived from the next state so they are
        // valid exactly during the cycle spent in that state.
        busy_d      = (state_d != IDLE) && (state_d != DONE);
        done_d      = (state_d == DONE);
        edge_rd_d   = (state_d == E_REQ);
        edge_addr_d = edge_rd_d ? idx_d : '0;
        pos_rd_d    = (state_d == A_REQ) || (state_d == B_REQ);
        if (state_d == A_REQ) begin
            pos_addr_d = ADDR_W'(a_d);
        end else if (state_d == B_REQ) begin
            pos_addr_d = ADDR_W'(b_d);
        end else begin
            pos_addr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            a_q            <= '0;
            b_q            <= '0;
            ax_q           <= '0;
            ay_q           <= '0;
            bx_q           <= '0;
            by_q           <= '0;
            dx_q           <= '0;
            dy_q           <= '0;
            skip_q         <= 1'b0;
            sum_manh_q     <= '0;
            sum_cheb_q     <= '0;
            sum_1hop_q     <= '0;
            max_len_q      <= '0;
            unplaced_cnt_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            edge_rd_q      <= 1'b0;
            edge_addr_q    <= '0;
            pos_rd_q       <= 1'b0;
            pos_addr_q     <= '0;
`ifdef PLACE_EVAL_CYCLES_EN
            cycles_q       <= '0;
`endif
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            a_q            <= a_d;
            b_q            <= b_d;
            ax_q           <= ax_d;
            ay_q           <= ay_d;
            bx_q           <= bx_d;
            by_q           <= by_d;
            dx_q           <= dx_d;
            dy_q           <= dy_d;
            skip_q         <= skip_d;
            sum_manh_q     <= sum_manh_d;
            sum_cheb_q     <= sum_cheb_d;
            sum_1hop_q     <= sum_1hop_d;
            max_len_q      <= max_len_d;
            unplaced_cnt_q <= unplaced_cnt_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            edge_rd_q      <= edge_rd_d;
            edge_addr_q    <= edge_addr_d;
            pos_rd_q       <= pos_rd_d;
            pos_addr_q     <= pos_addr_d;
`ifdef PLACE_EVAL_CYCLES_EN
            cycles_q       <= cycles_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.edge_rd   = edge_rd_q;
    assign bus.edge_addr = edge_addr_q;
    assign bus.pos_rd    = pos_rd_q;
    assign bus.pos_addr  = pos_addr_q;
    assign sum_manh      = sum_manh_q;
    assign sum_cheb      = sum_cheb_q;
    assign sum_1hop      = sum_1hop_q;
    assign max_len       = max_len_q;
    assign unplaced_cnt  = unplaced_cnt_q;
    assign state_dbg     = state_q;

`ifdef PLACE_EVAL_CYCLES_EN
    assign cycles = cycles_q;

    always @(posedge clk) begin
        if (!reset && state_q == DONE) begin
            $display("placement_cost_eval: manh=%0d cheb=%0d 1hop=%0d max_len=%0d unplaced=%0d cycles=%0d",
                     sum_manh_q, sum_cheb_q, sum_1hop_q, max_len_q, unplaced_cnt_q, cycles_q);
        end
    end
`endif

endmodule

// File: tb/tb_placement_cost_eval.sv
// tb_placement_cost_eval
// ----------------------
// Bench for placement_cost_eval. Two instances share the same edge/position
// memory contents: u_dut (22 edges) is checked every cycle against a
// behavioural model of the wirelength metrics and of the start/done timing;
// u_dut1 (1 edge) pins the single-edge latency and values with literals.
`timescale 1ns/1ps
module tb_placement_cost_eval;
    localparam int NE = 22;
    localparam int NN = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    placement_cost_eval_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();
    placement_cost_eval_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();

    logic [31:0] manh0, cheb0, hop0, maxl0, manh1, cheb1, hop1, maxl1;
    logic [15:0] unpl0, unpl1;
    logic [3:0]  st0, st1;
`ifdef PLACE_EVAL_CYCLES_EN
    logic [31:0] cycles0, cycles1;
`endif

    placement_cost_eval #(.N_EDGE(NE), .DATA_W(32), .ADDR_W(32), .ACC_W(32)) u_dut (
        .clk(clk), .reset(reset), .bus(bus0.slave),
        .sum_manh(manh0), .sum_cheb(cheb0), .sum_1hop(hop0), .max_len(maxl0),
        .unplaced_cnt(unpl0), .state_dbg(st0)
`ifdef PLACE_EVAL_CYCLES_EN
        , .cycles(cycles0)
`endif
    );

    placement_cost_eval #(.N_EDGE(1), .DATA_W(32), .ADDR_W(32), .ACC_W(32)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave),
        .sum_manh(manh1), .sum_cheb(cheb1), .sum_1hop(hop1), .max_len(maxl1),
        .unplaced_cnt(unpl1), .state_dbg(st1)
`ifdef PLACE_EVAL_CYCLES_EN
        , .cycles(cycles1)
`endif
    );

    // ---------------- memories ----------------
    logic [31:0] ea [NE];
    logic [31:0] eb [NE];
    logic [31:0] px [NN];
    logic [31:0] py [NN];

    function automatic logic [31:0] mem_e(input logic [31:0] ad, input bit sel_b);
        if (ad >= 32'(NE)) return '0;
        return sel_b ? eb[ad[4:0]] : ea[ad[4:0]];
    endfunction

    function automatic logic [31:0] mem_p(input logic [31:0] ad, input bit sel_y);
        if (ad >= 32'(NN)) return '1;
        return sel_y ? py[ad[5:0]] : px[ad[5:0]];
    endfunction

    initial forever begin
        @(posedge clk);
        if (bus0.edge_rd) begin
            bus0.edge_a <= mem_e(bus0.edge_addr, 1'b0);
            bus0.edge_b <= mem_e(bus0.edge_addr, 1'b1);
        end
        if (bus0.pos_rd) begin
            bus0.pos_x <= mem_p(bus0.pos_addr, 1'b0);
            bus0.pos_y <= mem_p(bus0.pos_addr, 1'b1);
        end
        if (bus1.edge_rd) begin
            bus1.edge_a <= mem_e(bus1.edge_addr, 1'b0);
            bus1.edge_b <= mem_e(bus1.edge_addr, 1'b1);
        end
        if (bus1.pos_rd) begin
            bus1.pos_x <= mem_p(bus1.pos_addr, 1'b0);
            bus1.pos_y <= mem_p(bus1.pos_addr, 1'b1);
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: metrics straight from the coordinate tables.
    task automatic model_eval(output logic [31:0] m, output logic [31:0] c,
                              output logic [31:0] h, output logic [31:0] ml,
                              output logic [15:0] u);
        longint sm, sc, sh, mx, dx, dy;
        int un;
        sm = 0; sc = 0; sh = 0; mx = 0; un = 0;
        for (int e = 0; e < NE; e++) begin
            logic [31:0] ax, ay, bx, by;
            ax = px[ea[e][5:0]]; ay = py[ea[e][5:0]];
            bx = px[eb[e][5:0]]; by = py[eb[e][5:0]];
            if (ax == 32'hFFFF_FFFF || ay == 32'hFFFF_FFFF ||
                bx == 32'hFFFF_FFFF || by == 32'hFFFF_FFFF) begin
                un++;
            end else begin
                dx = longint'($signed(ax)) - longint'($signed(bx));
                dy = longint'($signed(ay)) - longint'($signed(by));
                if (dx < 0) dx = -dx;
                if (dy < 0) dy = -dy;
                sm += dx + dy;
                sc += (dx > dy) ? dx : dy;
                sh += (dx + 1) / 2 + (dy + 1) / 2;
                if (dx + dy > mx) mx = dx + dy;
            end
        end
        m  = sm[31:0];
        c  = sc[31:0];
        h  = sh[31:0];
        ml = mx[31:0];
        u  = (un > 65535) ? 16'hFFFF : 16'(un);
    endtask

    // Cycle counter: tick = number of rising edges seen so far.
    int tick = 0;
    initial forever begin
        @(posedge clk);
        tick++;
    end

    // Compare process for u_dut: timing model (start taken only while idle,
    // done exactly 8*NE+1 cycles later) plus result model.
    initial begin
        bit run;
        int done_tick;
        logic [31:0] pm, pc, ph, pml, em, ec, eh, eml, ecyc;
        logic [15:0] pu, eu;
        run = 0; done_tick = 0;
        em = 0; ec = 0; eh = 0; eml = 0; eu = 0; ecyc = 0;
        pm = 0; pc = 0; ph = 0; pml = 0; pu = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                run = 0;
                em = 0; ec = 0; eh = 0; eml = 0; eu = 0; ecyc = 0;
                check("rst_busy", bus0.busy, 0);
                check("rst_done", bus0.done, 0);
                check("rst_edge_rd", bus0.edge_rd, 0);
                check("rst_edge_addr", bus0.edge_addr, 0);
                check("rst_pos_rd", bus0.pos_rd, 0);
                check("rst_pos_addr", bus0.pos_addr, 0);
                check("rst_manh", manh0, 0);
                check("rst_max", maxl0, 0);
                check("rst_unpl", unpl0, 0);
            end else begin
                if (run && tick < done_tick) begin
                    check("busy_running", bus0.busy, 1);
                    check("done_running", bus0.done, 0);
                end else begin
                    if (run && tick == done_tick) begin
                        em = pm; ec = pc; eh = ph; eml = pml; eu = pu;
                        ecyc = 32'(8 * NE + 1);
                        check("done_pulse", bus0.done, 1);
                    end else begin
                        check("done_idle", bus0.done, 0);
                        check("edge_rd_idle", bus0.edge_rd, 0);
                        check("pos_rd_idle", bus0.pos_rd, 0);
                    end
                    check("busy_idle", bus0.busy, 0);
                    check("sum_manh", manh0, em);
                    check("sum_cheb", cheb0, ec);
                    check("sum_1hop", hop0, eh);
                    check("max_len", maxl0, eml);
                    check("unplaced_cnt", unpl0, eu);
`ifdef PLACE_EVAL_CYCLES_EN
                    check("cycles", cycles0, ecyc);
`endif
                end
                if (bus0.start && !(run && tick <= done_tick)) begin
                    run = 1;
                    done_tick = tick + 1 + 8 * NE;
                    model_eval(pm, pc, ph, pml, pu);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    // Pulse start, optionally raise it again in loop cycles rep_a / rep_b
    // (cycle 1 = first cycle after the start cycle), wait for done.
    task automatic run0(input int rep_a, input int rep_b);
        int found;
        found = 0;
        @(posedge clk); #1 bus0.start = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1 bus0.start = (k == rep_a) || (k == rep_b);
            @(negedge clk);
            if (bus0.done) begin
                found = k;
                break;
            end
        end
        check("done_latency", found, 8 * NE + 1);
        @(posedge clk); #1 bus0.start = 1'b0;
    endtask

    task automatic clear_mem();
        for (int e = 0; e < NE; e++) begin ea[e] = 0; eb[e] = 0; end
        for (int n = 0; n < NN; n++) begin px[n] = 0; py[n] = 0; end
    endtask

    // Edges 0..2 have (|dx|,|dy|) = (1,0), (2,2), (0,5); the rest are node0-node0.
    task automatic load_case_a();
        clear_mem();
        px[0] = 7; py[0] = 7;
        ea[0] = 1; eb[0] = 2; ea[1] = 1; eb[1] = 3; ea[2] = 1; eb[2] = 4;
        px[1] = 0; py[1] = 0; px[2] = 1; py[2] = 0;
        px[3] = 2; py[3] = 2; px[4] = 0; py[4] = 5;
    endtask

    task automatic randomize_mem(input int mode);
        for (int e = 0; e < NE; e++) begin
            ea[e] = $urandom_range(0, NN - 1);
            eb[e] = $urandom_range(0, NN - 1);
        end
        for (int n = 0; n < NN; n++) begin
            if (mode == 1) begin
                px[n] = $urandom_range(0, 32'h1FFF_FFFF);
                py[n] = $urandom_range(0, 32'h1FFF_FFFF);
            end else begin
                px[n] = $urandom_range(0, 40);
                py[n] = $urandom_range(0, 40);
                if (mode == 2 && $urandom_range(0, 99) < 8) px[n] = '1;
                if (mode == 2 && $urandom_range(0, 99) < 8) py[n] = '1;
            end
        end
    endtask

    task automatic check_lit0(input string tag, input logic [31:0] m, input logic [31:0] c,
                              input logic [31:0] h, input logic [31:0] ml, input logic [15:0] u);
        check({tag, "_manh"}, manh0, m);
        check({tag, "_cheb"}, cheb0, c);
        check({tag, "_1hop"}, hop0, h);
        check({tag, "_max"}, maxl0, ml);
        check({tag, "_unpl"}, unpl0, u);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int extra;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        check("rst1_busy", bus1.busy, 0);
        check("rst1_done", bus1.done, 0);
        check("rst1_manh", manh1, 0);
        check("rst1_unpl", unpl1, 0);
        reset = 1'b0;

        // Single edge (0,1): pos0=(0,0), pos1=(3,1).
        ea[0] = 0; eb[0] = 1; px[1] = 3; py[1] = 1;
        @(posedge clk); #1 bus1.start = 1'b1;
        lat = 0;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1 bus1.start = 1'b0;
            @(negedge clk);
            if (bus1.done) begin
                lat = k;
                break;
            end
        end
        check("n1_latency", lat, 9);
        check("n1_manh", manh1, 4);
        check("n1_cheb", cheb1, 3);
        check("n1_1hop", hop1, 3);
        check("n1_max", maxl1, 4);
        check("n1_unpl", unpl1, 0);
`ifdef PLACE_EVAL_CYCLES_EN
        check("n1_cycles", cycles1, 9);
`endif

        // Three meaningful edges.
        load_case_a();
        run0(0, 0);
        check_lit0("case_a", 10, 8, 6, 5, 0);
`ifdef PLACE_EVAL_CYCLES_EN
        check("case_a_cycles", cycles0, 177);
`endif

        // Node 3 unplaced: edge 1 drops out.
        px[3] = '1;
        run0(0, 0);
        check_lit0("unplaced", 6, 6, 4, 5, 1);

        // Start re-pulsed while busy and in the done cycle: one run only.
        load_case_a();
        run0(20, 8 * NE + 1);
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus0.done) extra++;
        end
        check("no_extra_done", extra, 0);
        check_lit0("restart", 10, 8, 6, 5, 0);

        // Reset during B_WAIT of edge 1 (14 cycles after the start cycle).
        @(posedge clk); #1 bus0.start = 1'b1;
        @(posedge clk); #1 bus0.start = 1'b0;
        repeat (13) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_busy", bus0.busy, 0);
        check("midrst_done", bus0.done, 0);
        check_lit0("midrst", 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        run0(0, 0);
        check_lit0("after_rst", 10, 8, 6, 5, 0);

        // Randomized runs, some with an ignored start pulse while busy.
        for (int r = 0; r < 24; r++) begin
            randomize_mem(r % 3);
            run0(($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 8 * NE - 4)) : 0, 0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/placement_cost_eval.md
Name: placement_cost_eval

Overview:
- Downstream stage of the placement engine. Runs after placement asserts `out`.
- Walks the edge list (EA/EB ROMs) and the final position RAMs (pos_X/pos_Y).
- Computes per-design wirelength metrics: Manhattan, Chebyshev and 1-hop sums, plus the longest edge.
- Counts edges whose endpoints were never placed.
- Start/done handshake, so a top-level controller can chain it after placement.

Parameters:
- N_EDGE, 22, number of edges to evaluate (addresses 0..N_EDGE-1)
- DATA_W, 32, width of node IDs and coordinates (signed)
- ADDR_W, 32, width of memory address outputs
- ACC_W, 32, width of the sum accumulators (unsigned)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  one-cycle request; sampled only in IDLE
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when results are valid
- edge_rd  output  1  read strobe to EA and EB ROMs
- edge_addr  output  ADDR_W  edge index
- edge_a  input  DATA_W  ROM data, node A
- edge_b  input  DATA_W  ROM data, node B
- pos_rd  output  1  read strobe to pos_X and pos_Y RAMs
- pos_addr  output  ADDR_W  node ID
- pos_x  input  DATA_W  X coordinate; -1 = unplaced
- pos_y  input  DATA_W  Y coordinate; -1 = unplaced
- sum_manh  output  ACC_W  Σ(|dx|+|dy|)
- sum_cheb  output  ACC_W  Σ max(|dx|,|dy|)
- sum_1hop  output  ACC_W  Σ(ceil(|dx|/2)+ceil(|dy|/2))
- max_len  output  DATA_W  largest |dx|+|dy| over placed edges
- unplaced_cnt  output  16  count of skipped edges

Behaviour:
- Reset (async, immediate): state=IDLE; every output 0; edge index 0. Reset mid-run aborts the run with no done pulse.
- Memory timing: rd/addr are registered outputs, high for exactly the request-state cycle. The memory samples them at the edge ending that cycle. Data is captured at the edge ending the following WAIT cycle.
- FSM:
  - IDLE: if start, clear all result registers and index → E_REQ; if N_EDGE==0 → DONE.
  - E_REQ: edge_rd=1, edge_addr=i → E_WAIT.
  - E_WAIT: latch a=edge_a, b=edge_b → A_REQ.
  - A_REQ: pos_rd=1, pos_addr=a → A_WAIT.
  - A_WAIT: latch ax, ay → B_REQ.
  - B_REQ: pos_rd=1, pos_addr=b → B_WAIT.
  - B_WAIT: latch bx, by → CALC.
  - CALC: dx=|ax-bx|, dy=|ay-by| using signed DATA_W subtraction then absolute value. Set skip flag if any of ax, ay, bx, by == -1 → ACC.
  - ACC:
    - Skipped edge: unplaced_cnt+1, saturating at 16'hFFFF.
    - Placed edge: update all three sums (wrap modulo 2^ACC_W) and max_len (update only on strictly greater).
    - If i==N_EDGE-1 → DONE; else i+1 → E_REQ.
  - DONE: done=1 for one cycle; busy falls in the same cycle → IDLE.
- Latency: 8 cycles per edge. Done asserts 8*N_EDGE+1 cycles after the start-sampling edge.
- busy: asserted in every state except IDLE and DONE.
- start while busy or in DONE: ignored.
- Results hold their values from done until the next accepted start.
- Chebyshev and 1-hop terms are computed from the same dx/dy. ceil(v/2) = (v>>1)+v[0].

Optional Feature:
- Macro: PLACE_EVAL_CYCLES_EN.
- Defined:
  - Adds output `cycles` (32 bits): counts clock cycles from the accepted start through the DONE cycle inclusive.
  - Held after done; cleared by reset and on the next start.
  - Adds a `$display` of all results in DONE.
- Undefined: no `cycles` port, no counter logic, no display. All other behaviour is identical.

Test Plan:
- N_EDGE=1, edge (0,1), pos0=(0,0), pos1=(3,1) → sum_manh=4, sum_cheb=3, sum_1hop=3, max_len=4, unplaced_cnt=0; done exactly 9 cycles after start.
- N_EDGE=3, edges with |dx|,|dy| = (1,0), (2,2), (0,5) → sum_manh=10, sum_cheb=8, sum_1hop=1+2+3=6, max_len=5.
- One endpoint with pos_x=-1 among 3 edges → that edge contributes nothing; unplaced_cnt=1; other sums correct.
- Start re-pulsed while busy and again in the DONE cycle → single run, one done pulse, results unchanged.
- Reset asserted mid-run (during B_WAIT of edge 1) → all outputs 0 in the same cycle, no done pulse; a new start then completes normally.
- With PLACE_EVAL_CYCLES_EN, N_EDGE=22 → cycles=177; without the macro the bench compiles without `cycles`.
